// File: rtl/idct4_pkg.sv
// Shared constants and helpers for the 4-point HEVC inverse core transform.
package idct4_pkg;

   // HEVC 4-point DCT basis coefficients.
   localparam int C64 = 64;
   localparam int C83 = 83;
   localparam int C36 = 36;

   // Rounding shifts for the first pass and for the second pass at 8-bit depth.
   localparam int IDCT_SHIFT1 = 7;
   localparam int IDCT_SHIFT2 = 12;

   // Accumulator width: enough headroom for 64*(a+b) + 119*c on WIDTH_X inputs.
   function automatic int acc_w(input int width_x);
      return width_x + 9;
   endfunction

endpackage

// File: rtl/idct4_pipe_rnd_sat.sv
// Combinational round / arithmetic shift / output sizing of one butterfly lane.
// Build option IDCT4_CLIP_EN: defined -> clamp to the signed WIDTH_Y range,
// undefined -> keep the WIDTH_Y LSBs (two's-complement wrap).
module idct4_rnd_sat #(
   parameter int ACC_W   = 25,
   parameter int WIDTH_Y = 16,
   parameter int SHIFT   = 7
) (
   input  logic signed [ACC_W-1:0]   s_i,
   output logic        [WIDTH_Y-1:0] r_o
);

   logic signed [ACC_W-1:0] rnd;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] shr;

   // Round half up, then floor-shift (arithmetic).
   assign rnd = ACC_W'(1) <<< (SHIFT - 1);
   assign sum = s_i + rnd;
   assign shr = sum >>> SHIFT;

`ifdef IDCT4_CLIP_EN
   logic signed [ACC_W-1:0] y_max;
   logic signed [ACC_W-1:0] y_min;

   assign y_max = {{(ACC_W-WIDTH_Y+1){1'b0}}, {(WIDTH_Y-1){1'b1}}};
   assign y_min = ~y_max;

   // Clamp the shifted value into the representable output range.
   always_comb begin
      r_o = WIDTH_Y'(shr);
      if (shr > y_max) begin
         r_o = {1'b0, {(WIDTH_Y-1){1'b1}}};
      end else if (shr < y_min) begin
         r_o = {1'b1, {(WIDTH_Y-1){1'b0}}};
      end
   end
`else
   // Conformant streams never exceed WIDTH_Y, so plain truncation suffices.
   assign r_o = WIDTH_Y'(shr);
`endif

endmodule

// File: rtl/idct4_pipe.sv
// 4-point HEVC inverse core transform (partial butterfly), one row/column per
// beat, as a three-stage elastic pipeline: S1 input reg, S2 butterfly reg,
// S3 rounded/sized output reg.
// Build option IDCT4_CLIP_EN selects saturation (defined) or wrap (undefined)
// of the outputs; see idct4_rnd_sat.
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both high. The source holds valid and data stable until that edge;
// in_ready depends only on out_ready and internal valid flags, never on in_valid.
module idct4_pipe #(
   parameter int WIDTH_X = 16,
   parameter int WIDTH_Y = 16,
   parameter int SHIFT   = idct4_pkg::IDCT_SHIFT1
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_X-1:0] c0,
   input  logic [WIDTH_X-1:0] c1,
   input  logic [WIDTH_X-1:0] c2,
   input  logic [WIDTH_X-1:0] c3,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_Y-1:0] r0,
   output logic [WIDTH_Y-1:0] r1,
   output logic [WIDTH_Y-1:0] r2,
   output logic [WIDTH_Y-1:0] r3
);
   import idct4_pkg::*;

   localparam int ACC_W = acc_w(WIDTH_X);
   localparam int EXT   = ACC_W - WIDTH_X;

   // Constant multiply as a sum of shifted copies; k is a compile-time constant
   // so this folds to adders only.
   function automatic logic signed [ACC_W-1:0] mul_const(input logic signed [ACC_W-1:0] x,
                                                         input logic [7:0] k);
      logic signed [ACC_W-1:0] acc;
      acc = '0;
      for (int b = 0; b < 8; b++) begin
         if (k[b]) acc = acc + (x <<< b);
      end
      return acc;
   endfunction

   logic v1_q, v2_q, v3_q;
   logic ld1, ld2, ld3;

   logic [WIDTH_X-1:0] c0_q, c1_q, c2_q, c3_q;
   logic signed [ACC_W-1:0] x0, x1, x2, x3;
   logic signed [ACC_W-1:0] e0_d, e1_d, o0_d, o1_d;
   logic signed [ACC_W-1:0] e0_q, e1_q, o0_q, o1_q;
   logic signed [ACC_W-1:0] s0, s1, s2, s3;
   logic [WIDTH_Y-1:0] r0_d, r1_d, r2_d, r3_d;
   logic [WIDTH_Y-1:0] r0_q, r1_q, r2_q, r3_q;

   // A stage advances when it is empty or its downstream advances; bubbles collapse.
   assign ld3      = !v3_q || out_ready;
   assign ld2      = !v2_q || ld3;
   assign ld1      = !v1_q || ld2;
   assign in_ready = ld1;

   // S1: capture the accepted input beat; loading with no input empties the slot.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         v1_q <= 1'b0;
         c0_q <= '0;
         c1_q <= '0;
         c2_q <= '0;
         c3_q <= '0;
      end else if (ld1) begin
         v1_q <= in_valid;
         if (in_valid) begin
            c0_q <= c0;
            c1_q <= c1;
            c2_q <= c2;
            c3_q <= c3;
         end
      end
   end

   assign x0 = {{EXT{c0_q[WIDTH_X-1]}}, c0_q};
   assign x1 = {{EXT{c1_q[WIDTH_X-1]}}, c1_q};
   assign x2 = {{EXT{c2_q[WIDTH_X-1]}}, c2_q};
   assign x3 = {{EXT{c3_q[WIDTH_X-1]}}, c3_q};

   // Even/odd halves of the partial butterfly.
   always_comb begin
      e0_d = mul_const(x0 + x2, 8'(C64));
      e1_d = mul_const(x0 - x2, 8'(C64));
      o0_d = mul_const(x1, 8'(C83)) + mul_const(x3, 8'(C36));
      o1_d = mul_const(x1, 8'(C36)) - mul_const(x3, 8'(C83));
   end

   // S2: register the butterfly terms.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         v2_q <= 1'b0;
         e0_q <= '0;
         e1_q <= '0;
         o0_q <= '0;
         o1_q <= '0;
      end else if (ld2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            o0_q <= o0_d;
            o1_q <= o1_d;
         end
      end
   end

   assign s0 = e0_q + o0_q;
   assign s1 = e1_q + o1_q;
   assign s2 = e1_q - o1_q;
   assign s3 = e0_q - o0_q;

   idct4_rnd_sat #(.ACC_W(ACC_W), .WIDTH_Y(WIDTH_Y), .SHIFT(SHIFT)) u_rs0 (.s_i(s0), .r_o(r0_d));
   idct4_rnd_sat #(.ACC_W(ACC_W), .WIDTH_Y(WIDTH_Y), .SHIFT(SHIFT)) u_rs1 (.s_i(s1), .r_o(r1_d));
   idct4_rnd_sat #(.ACC_W(ACC_W), .WIDTH_Y(WIDTH_Y), .SHIFT(SHIFT)) u_rs2 (.s_i(s2), .r_o(r2_d));
   idct4_rnd_sat #(.ACC_W(ACC_W), .WIDTH_Y(WIDTH_Y), .SHIFT(SHIFT)) u_rs3 (.s_i(s3), .r_o(r3_d));

   // S3: output register; holds its beat while downstream stalls.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         v3_q <= 1'b0;
         r0_q <= '0;
         r1_q <= '0;
         r2_q <= '0;
         r3_q <= '0;
      end else if (ld3) begin
         v3_q <= v2_q;
         if (v2_q) begin
            r0_q <= r0_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
         end
      end
   end

   assign out_valid = v3_q;
   assign r0 = r0_q;
   assign r1 = r1_q;
   assign r2 = r2_q;
   assign r3 = r3_q;

endmodule
